// File: rtl/iq_hop_scheduler.sv
// iq_hop_scheduler
//   Frequency-hop sequencer for the 8-lane IQ frequency shifter. It holds a table of
//   (phase increment, dwell) pairs and steps through them in order. The current entry's
//   increment drives the shifter's dds_phase_inc. A settled qualifier stays low while the
//   DDS and complex-multiply pipeline is still flushing the previous frequency.
//
//   Optional feature macro: HOP_SCHED_CNT_EN
//     When defined, this adds hop_count_o. It is a 32-bit saturating count of hop strobes
//     since reset.
//
// Ports
//   clock_i            sole clock, posedge
//   reset_i            synchronous, active-high
//   cfg_wr_en_i        table write strobe (dropped while busy)
//   cfg_wr_addr_i      table write address
//   cfg_wr_inc_i       phase increment to store
//   cfg_wr_dwell_i     dwell in clocks to store (0 behaves as 1)
//   cfg_num_entries_i  active entry count, sampled on start, clamped to DEPTH
//   cfg_loop_i         sampled on start: 1 = wrap to entry 0, 0 = single pass
//   start_i            pulse: begin sequence at entry 0
//   stop_i             pulse: abort to idle (wins over start)
//   dds_phase_inc_o    phase increment to the shifter
//   hop_strobe_o       pulse on the cycle dds_phase_inc_o takes a new entry
//   settled_o          shifter output reflects the current dds_phase_inc_o
//   busy_o             sequencer running
//   hop_index_o        table entry currently driven
//   done_o             pulse at the end of a single pass or on stop while busy
//   cfg_wr_err_o       pulse: a write was attempted while busy
//   hop_count_o        (HOP_SCHED_CNT_EN only) saturating hop strobe count

module iq_hop_scheduler #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned DWELL_W       = 24,
    parameter int unsigned SETTLE_CYCLES = 12,
    localparam int unsigned ADDR_W       = $clog2(DEPTH)
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                cfg_wr_en_i,
    input  logic [ADDR_W-1:0]   cfg_wr_addr_i,
    input  logic [15:0]         cfg_wr_inc_i,
    input  logic [DWELL_W-1:0]  cfg_wr_dwell_i,
    input  logic [ADDR_W:0]     cfg_num_entries_i,
    input  logic                cfg_loop_i,
    input  logic                start_i,
    input  logic                stop_i,
    output logic [15:0]         dds_phase_inc_o,
    output logic                hop_strobe_o,
    output logic                settled_o,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   hop_index_o,
    output logic                done_o,
    output logic                cfg_wr_err_o
`ifdef HOP_SCHED_CNT_EN
    ,
    output logic [31:0]         hop_count_o
`endif
);

    localparam int unsigned SetW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [ADDR_W:0] NumMax = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [15:0]           inc_mem   [DEPTH];
    logic [DWELL_W-1:0]    dwell_mem [DEPTH];

    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [15:0]           inc_q, inc_d;
    logic [DWELL_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W:0]       num_q, num_d;
    logic                  loop_q, loop_d;
    logic                  strobe_q, strobe_d;
    logic                  done_q, done_d;
    logic                  err_q;
    logic [SetW-1:0]       settle_q, settle_d;

    logic [ADDR_W:0]       num_clamped;
    logic                  load;
    logic [ADDR_W-1:0]     load_idx;
    logic                  busy;

    assign busy        = (state_q == StRun);
    assign num_clamped = (cfg_num_entries_i > NumMax) ? NumMax : cfg_num_entries_i;

    // Next-state and hop loading
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        inc_d    = inc_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        loop_d   = loop_q;
        done_d   = 1'b0;
        load     = 1'b0;
        load_idx = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !stop_i && (num_clamped != '0)) begin
                    state_d  = StRun;
                    num_d    = num_clamped;
                    loop_d   = cfg_loop_i;
                    load     = 1'b1;
                    load_idx = '0;
                end
            end
            StRun: begin
                if (stop_i) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (cnt_q <= DWELL_W'(1)) begin
                    if ({1'b0, idx_q} == (num_q - (ADDR_W + 1)'(1))) begin
                        if (loop_q) begin
                            load     = 1'b1;
                            load_idx = '0;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        load     = 1'b1;
                        load_idx = idx_q + ADDR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            idx_d = load_idx;
            inc_d = inc_mem[load_idx];
            // A zero dwell still occupies one cycle.
            cnt_d = (dwell_mem[load_idx] == '0) ? DWELL_W'(1) : dwell_mem[load_idx];
        end
        strobe_d = load;

        // Cycles since the last hop, saturating; restarts on every hop.
        if (load) begin
            settle_d = '0;
        end else if (settle_q == SetW'(SETTLE_CYCLES)) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + SetW'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            inc_q    <= '0;
            cnt_q    <= '0;
            num_q    <= '0;
            loop_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            inc_q    <= inc_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            loop_q   <= loop_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= cfg_wr_en_i && busy;
            settle_q <= settle_d;
        end
    end

    // Table storage is deliberately not reset.
    always_ff @(posedge clock_i) begin
        if (cfg_wr_en_i && !busy) begin
            inc_mem[cfg_wr_addr_i]   <= cfg_wr_inc_i;
            dwell_mem[cfg_wr_addr_i] <= cfg_wr_dwell_i;
        end
    end

`ifdef HOP_SCHED_CNT_EN
    logic [31:0] hop_cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hop_cnt_q <= '0;
        end else if (strobe_d && (hop_cnt_q != '1)) begin
            hop_cnt_q <= hop_cnt_q + 32'd1;
        end
    end

    assign hop_count_o = hop_cnt_q;
`endif

    assign dds_phase_inc_o = inc_q;
    assign hop_strobe_o    = strobe_q;
    assign settled_o       = (settle_q == SetW'(SETTLE_CYCLES));
    assign busy_o          = busy;
    assign hop_index_o     = idx_q;
    assign done_o          = done_q;
    assign cfg_wr_err_o    = err_q;

endmodule

// File: tb/tb_iq_hop_scheduler.sv
// Self-checking bench for iq_hop_scheduler (DEPTH=16, DWELL_W=24, SETTLE_CYCLES=12).
// Expected per-cycle outputs are queued as stimulus is prepared, then popped and compared
// one cycle at a time, 1 ns after each rising edge.

module tb_iq_hop_scheduler;

    localparam int unsigned Settle = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_inc;
    logic [23:0] wr_dwell;
    logic [4:0]  num;
    logic        lp;
    logic        start;
    logic        stop;
    logic [15:0] dds_inc;
    logic        strobe;
    logic        settled;
    logic        busy;
    logic [3:0]  hop_index;
    logic        done;
    logic        wr_err;
`ifdef HOP_SCHED_CNT_EN
    logic [31:0] hop_count;
`endif

    always #5 clk = ~clk;

    iq_hop_scheduler #(
        .DEPTH         (16),
        .DWELL_W       (24),
        .SETTLE_CYCLES (Settle)
    ) dut (
        .clock_i           (clk),
        .reset_i           (reset),
        .cfg_wr_en_i       (wr_en),
        .cfg_wr_addr_i     (wr_addr),
        .cfg_wr_inc_i      (wr_inc),
        .cfg_wr_dwell_i    (wr_dwell),
        .cfg_num_entries_i (num),
        .cfg_loop_i        (lp),
        .start_i           (start),
        .stop_i            (stop),
        .dds_phase_inc_o   (dds_inc),
        .hop_strobe_o      (strobe),
        .settled_o         (settled),
        .busy_o            (busy),
        .hop_index_o       (hop_index),
        .done_o            (done),
        .cfg_wr_err_o      (wr_err)
`ifdef HOP_SCHED_CNT_EN
        ,
        .hop_count_o       (hop_count)
`endif
    );

    typedef struct {
        logic [15:0] inc;
        logic        strobe;
        logic        busy;
        logic [3:0]  idx;
        logic        done;
        logic        err;
        logic        settled;
        logic [31:0] hcnt;
    } exp_t;

    typedef struct {
        logic        start;
        logic        stop;
        logic        wr_en;
        logic [3:0]  addr;
        logic [15:0] winc;
        logic [23:0] wdwell;
        logic [4:0]  num;
        logic        lp;
        logic [15:0] e_inc;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned since    = 0;
    int unsigned hcnt_exp = 0;
    int          settled_hi = 0;
    logic [15:0] tinc[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Queue one cycle's expected outputs; settled follows the time since the last hop.
    task automatic push_exp(input logic [15:0] inc, input logic stb, input logic bsy,
                            input logic [3:0] idx, input logic dn, input logic err);
        exp_t e;
        if (stb) begin
            since = 0;
            hcnt_exp++;
        end else if (since < Settle) begin
            since++;
        end
        e.inc = inc; e.strobe = stb; e.busy = bsy; e.idx = idx; e.done = dn; e.err = err;
        e.settled = (since >= Settle);
        e.hcnt = hcnt_exp;
        exp_q.push_back(e);
    endtask

    task automatic push_reset();
        exp_t e;
        since = 0;
        hcnt_exp = 0;
        e.inc = '0; e.strobe = 0; e.busy = 0; e.idx = '0; e.done = 0; e.err = 0;
        e.settled = 0; e.hcnt = 0;
        exp_q.push_back(e);
    endtask

    task automatic exp_hop(input logic [3:0] idx, input logic [15:0] inc, input int ncyc);
        for (int c = 0; c < ncyc; c++) push_exp(inc, (c == 0), 1'b1, idx, 1'b0, 1'b0);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no entry expected one at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("dds_phase_inc", 32'(dds_inc), 32'(e.inc));
            check("hop_strobe", 32'(strobe), 32'(e.strobe));
            check("busy", 32'(busy), 32'(e.busy));
            check("hop_index", 32'(hop_index), 32'(e.idx));
            check("done", 32'(done), 32'(e.done));
            check("cfg_wr_err", 32'(wr_err), 32'(e.err));
            check("settled", 32'(settled), 32'(e.settled));
`ifdef HOP_SCHED_CNT_EN
            check("hop_count", hop_count, e.hcnt);
`endif
        end
        if (settled === 1'b1) settled_hi++;
        start = 0;
        stop  = 0;
        wr_en = 0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] inc, input logic [23:0] dw);
        wr_en = 1; wr_addr = a; wr_inc = inc; wr_dwell = dw;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        // IDLE-state vectors: table writes, ignored starts and stops.
        //            start stop wr  addr winc      wdwell  num lp  e_inc  busy err
        vecs[0] = '{0, 0, 1, 4'd0,  16'h1000, 24'd5,  5'd0, 0, 16'h0, 0, 0};
        vecs[1] = '{0, 0, 1, 4'd1,  16'h2000, 24'd20, 5'd0, 0, 16'h0, 0, 0};
        vecs[2] = '{1, 0, 0, 4'd0,  16'h0,    24'd0,  5'd0, 0, 16'h0, 0, 0};
        vecs[3] = '{1, 1, 0, 4'd0,  16'h0,    24'd0,  5'd2, 0, 16'h0, 0, 0};
        vecs[4] = '{0, 1, 0, 4'd0,  16'h0,    24'd0,  5'd2, 0, 16'h0, 0, 0};
        vecs[5] = '{1, 0, 0, 4'd0,  16'h0,    24'd0,  5'd0, 1, 16'h0, 0, 0};
        vecs[6] = '{0, 0, 1, 4'd15, 16'hF00F, 24'd9,  5'd0, 0, 16'h0, 0, 0};

        reset = 1; wr_en = 0; wr_addr = 0; wr_inc = 0; wr_dwell = 0;
        num = 0; lp = 0; start = 0; stop = 0;

        push_reset(); push_reset();
        run(2);
        reset = 0;
        // settled rises 12 clocks after reset release and then holds
        for (int i = 0; i < 13; i++) push_exp(16'h0, 0, 0, 4'd0, 0, 0);
        run(13);

        for (int i = 0; i < 7; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; wr_en = vecs[i].wr_en;
            wr_addr = vecs[i].addr; wr_inc = vecs[i].winc; wr_dwell = vecs[i].wdwell;
            num = vecs[i].num; lp = vecs[i].lp;
            push_exp(vecs[i].e_inc, 0, vecs[i].e_busy, 4'd0, 0, vecs[i].e_err);
            tick();
        end

        // Single pass over two entries
        num = 2; lp = 0; start = 1;
        exp_hop(4'd0, 16'h1000, 5);
        exp_hop(4'd1, 16'h2000, 20);
        push_exp(16'h2000, 0, 0, 4'd1, 1, 0);
        push_exp(16'h2000, 0, 0, 4'd1, 0, 0);
        run(27);

        // Looping: settled only in the last 8 cycles of entry 1
        lp = 1; start = 1; settled_hi = 0;
        exp_hop(4'd0, 16'h1000, 5); exp_hop(4'd1, 16'h2000, 20);
        exp_hop(4'd0, 16'h1000, 5); exp_hop(4'd1, 16'h2000, 20);
        push_exp(16'h1000, 1, 1, 4'd0, 0, 0);
        run(51);
        check("settled_cycles_two_loops", 32'(settled_hi), 32'd16);
        stop = 1;
        push_exp(16'h1000, 0, 0, 4'd0, 1, 0);
        tick();

        // Write while running is dropped and flagged
        start = 1;
        exp_hop(4'd0, 16'h1000, 3);
        run(3);
        write(4'd0, 16'hDEAD, 24'd7);
        push_exp(16'h1000, 0, 1, 4'd0, 0, 1);
        tick();
        stop = 1;
        push_exp(16'h1000, 0, 0, 4'd0, 1, 0);
        tick();
        push_exp(16'h1000, 0, 0, 4'd0, 0, 0);
        tick();
        num = 1; lp = 0; start = 1;
        exp_hop(4'd0, 16'h1000, 5);
        push_exp(16'h1000, 0, 0, 4'd0, 1, 0);
        run(6);

        // Stop mid-dwell in entry 1; a start while busy is ignored
        num = 2; lp = 0; start = 1;
        exp_hop(4'd0, 16'h1000, 5);
        exp_hop(4'd1, 16'h2000, 10);
        run(7);
        start = 1;
        run(8);
        stop = 1;
        push_exp(16'h2000, 0, 0, 4'd1, 1, 0);
        tick();
        push_exp(16'h2000, 0, 0, 4'd1, 0, 0);
        tick();

        // Full table of 1-cycle hops (even entries dwell 0), N=20 clamps to 16
        for (int i = 0; i < 16; i++) begin
            tinc[i] = 16'(i + 1) * 16'h0111;
            write(4'(i), tinc[i], (i % 2 == 0) ? 24'd0 : 24'd1);
            push_exp(16'h2000, 0, 0, 4'd1, 0, 0);
            tick();
        end
        num = 20; lp = 0; start = 1;
        for (int i = 0; i < 16; i++) push_exp(tinc[i], 1, 1, 4'(i), 0, 0);
        push_exp(tinc[15], 0, 0, 4'd15, 1, 0);
        run(17);

        // Single-entry loop with dwell 0: strobe every cycle, value unchanged
        num = 1; lp = 1; start = 1;
        for (int i = 0; i < 4; i++) push_exp(tinc[0], 1, 1, 4'd0, 0, 0);
        run(4);
        stop = 1;
        push_exp(tinc[0], 0, 0, 4'd0, 1, 0);
        tick();

        // Reset mid-run
        num = 2; lp = 1; start = 1;
        push_exp(tinc[0], 1, 1, 4'd0, 0, 0);
        push_exp(tinc[1], 1, 1, 4'd1, 0, 0);
        run(2);
        reset = 1;
        push_reset();
        tick();
        reset = 0;
        push_exp(16'h0, 0, 0, 4'd0, 0, 0);
        tick();

        // Three full loops of two entries
        write(4'd0, 16'h1000, 24'd5);
        push_exp(16'h0, 0, 0, 4'd0, 0, 0);
        tick();
        write(4'd1, 16'h2000, 24'd20);
        push_exp(16'h0, 0, 0, 4'd0, 0, 0);
        tick();
        num = 2; lp = 1; start = 1;
        for (int l = 0; l < 3; l++) begin
            exp_hop(4'd0, 16'h1000, 5);
            exp_hop(4'd1, 16'h2000, 20);
        end
        run(75);
        check("hops_after_three_loops", 32'(hcnt_exp), 32'd6);
`ifdef HOP_SCHED_CNT_EN
        check("hop_count_three_loops", hop_count, 32'd6);
`endif
        stop = 1;
        push_exp(16'h2000, 0, 0, 4'd1, 1, 0);
        tick();
        reset = 1;
        push_reset();
        tick();
        reset = 0;
`ifdef HOP_SCHED_CNT_EN
        check("hop_count_after_reset", hop_count, 32'd0);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
